lm70_spi_responder: RTL and testbench

//  SPI responder that emulates an LM70 temperature sensor for board bring-up and self-test.

---
 rtl/lm70_spi_responder.sv | 152 +++++++++++++++
 tb/tb_lm70_spi_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lm70_spi_responder.sv
// LM70 temperature-sensor emulator: answers a SPI read master with 16-bit frames
// {temp[10:0], 5'b11111}, temperature from a host-loaded register or a per-frame ramp.
module lm70_spi_responder #(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic signed [10:0] RESET_TEMP = 11'sd100,
    parameter logic signed [10:0] RAMP_MIN   = 11'sd0,
    parameter logic signed [10:0] RAMP_MAX   = 11'sd400,
    parameter logic signed [10:0] RAMP_STEP  = 11'sd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sck,
    output logic        sio_out,
    output logic        sio_oe,
    input  logic [10:0] temp_in,
    input  logic        temp_load,
    input  logic        mode_ramp,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
    logic        cs_d, sck_d;
    logic        cs_s, sck_s;
    logic        cs_fall, cs_rise, sck_rise, sck_fall;

    logic [15:0] shreg, shreg_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic        oe_nxt, done_nxt, abort_nxt;
    logic [7:0]  cnt_nxt;
    logic [10:0] temp_reg, temp_nxt;
    logic        ramp_fire;

    logic signed [11:0] ramp_sum, ramp_max_x;
    logic [10:0]        ramp_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    // Ramp step is done in 12 bits so the upper-bound test cannot overflow.
    assign ramp_sum   = $signed({temp_reg[10], temp_reg}) + $signed({RAMP_STEP[10], RAMP_STEP});
    assign ramp_max_x = $signed({RAMP_MAX[10], RAMP_MAX});
    assign ramp_next  = (ramp_sum > ramp_max_x) ? RAMP_MIN : ramp_sum[10:0];

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        oe_nxt      = sio_oe;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;
        cnt_nxt     = frame_cnt;
        temp_nxt    = temp_reg;
        ramp_fire   = 1'b0;

        if (cs_rise) begin
            state_nxt   = IDLE;
            oe_nxt      = 1'b0;
            bit_cnt_nxt = '0;
            if (state == DONE) begin
                done_nxt  = 1'b1;
                cnt_nxt   = frame_cnt + 8'd1;
                ramp_fire = mode_ramp;
            end else if (state == SHIFT) begin
                abort_nxt = 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shreg_nxt   = {temp_reg, 5'b11111};
                        bit_cnt_nxt = '0;
                        oe_nxt      = 1'b1;
                        state_nxt   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (!cs_s) begin
                        if (sck_rise) begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) begin
                                state_nxt = DONE;
                            end
                        end else if (sck_fall && bit_cnt != 5'd0 && bit_cnt < 5'd16) begin
                            shreg_nxt = {shreg[14:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (temp_load) begin
            temp_nxt = temp_in;
        end else if (ramp_fire) begin
            temp_nxt = ramp_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            sio_oe      <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_cnt   <= '0;
            temp_reg    <= RESET_TEMP;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            sio_oe      <= oe_nxt;
            frame_done  <= done_nxt;
            frame_abort <= abort_nxt;
            frame_cnt   <= cnt_nxt;
            temp_reg    <= temp_nxt;
        end
    end

    assign sio_out = (state == SHIFT) & shreg[15];
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Bench for lm70_spi_responder: SPI master model driving directed and random frames,
// expected words from an integer temperature/frame-count model.
module tb_lm70_spi_responder;

    logic        clk = 1'b0;
    logic        rst, cs_n, sck, sio_out, sio_oe, temp_load, mode_ramp;
    logic        busy, frame_done, frame_abort;
    logic [10:0] temp_in;
    logic [7:0]  frame_cnt;

    int passes = 0;
    int total  = 0;
    int done_seen  = 0;
    int abort_seen = 0;
    int model_temp;
    int model_cnt;
    logic [15:0] last_word;

    always #5 clk = ~clk;

    lm70_spi_responder #(
        .SYNC_STAGES(2),
        .RESET_TEMP (11'sd100),
        .RAMP_MIN   (11'sd0),
        .RAMP_MAX   (11'sd400),
        .RAMP_STEP  (11'sd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .sck        (sck),
        .sio_out    (sio_out),
        .sio_oe     (sio_oe),
        .temp_in    (temp_in),
        .temp_load  (temp_load),
        .mode_ramp  (mode_ramp),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .frame_cnt  (frame_cnt)
    );

    always @(negedge clk) begin
        if (frame_done)  done_seen++;
        if (frame_abort) abort_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_load(input logic [10:0] v);
        temp_in   = v;
        temp_load = 1'b1;
        @(negedge clk);
        temp_load = 1'b0;
    endtask

    function automatic int ramp_step(input int t);
        return (t + 4 > 400) ? 0 : t + 4;
    endfunction

    // special: 0 none, 1 temp_load aligned with CS-fall capture, 2 aligned with CS-rise/frame_done
    task automatic frame(input int nbits, input int mid_bit, input logic [10:0] mid_val,
                         input int special, input logic [10:0] sp_val, input int rst_bit);
        logic [15:0] word;
        logic [15:0] exp_word;
        int d0, a0;
        word     = '0;
        exp_word = {model_temp[10:0], 5'b11111};
        d0 = done_seen;
        a0 = abort_seen;
        @(negedge clk);
        cs_n = 1'b0;
        if (special == 1) begin
            repeat (2) @(negedge clk);
            pulse_load(sp_val);
            model_temp = $signed(sp_val);
            repeat (4) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                #1;
                check("rst_async_oe", 32'(sio_oe), 32'd0);
                check("rst_async_busy", 32'(busy), 32'd0);
                check("rst_async_cnt", 32'(frame_cnt), 32'd0);
                cs_n = 1'b1;
                sck  = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                model_temp = 100;
                model_cnt  = 0;
                repeat (4) @(negedge clk);
                return;
            end
            word = {word[14:0], sio_out};
            if (i == 0) begin
                check("oe_in_frame", 32'(sio_oe), 32'd1);
                check("busy_in_frame", 32'(busy), 32'd1);
            end
            if (i == mid_bit) begin
                pulse_load(mid_val);
                model_temp = $signed(mid_val);
            end
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
            repeat (5) @(negedge clk);
        end
        cs_n = 1'b1;
        if (nbits == 16) begin
            model_cnt = (model_cnt + 1) % 256;
            if (special == 2)   model_temp = $signed(sp_val);
            else if (mode_ramp) model_temp = ramp_step(model_temp);
        end
        if (special == 2) begin
            repeat (2) @(negedge clk);
            pulse_load(sp_val);
            repeat (6) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        last_word = word;
        if (nbits == 16) check("frame_word", 32'(word), 32'(exp_word));
        check("done_pulses", 32'(done_seen - d0), (nbits == 16) ? 32'd1 : 32'd0);
        check("abort_pulses", 32'(abort_seen - a0), (nbits == 16) ? 32'd0 : 32'd1);
        check("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
        check("oe_after_cs", 32'(sio_oe), 32'd0);
        check("busy_after_cs", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0;
        temp_load = 1'b0; temp_in = '0; mode_ramp = 1'b0;
        model_temp = 100;
        model_cnt  = 0;
        last_word  = '0;
        repeat (3) @(negedge clk);
        check("rst_sio_out", 32'(sio_out), 32'd0);
        check("rst_sio_oe", 32'(sio_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        pulse_load(11'h064);
        model_temp = 100;
        frame(16, -1, '0, 0, '0, -1);
        check("t1_word", 32'(last_word), 32'h0C9F);

        pulse_load(11'h79C);
        model_temp = -100;
        frame(16, 5, 11'h000, 0, '0, -1);
        check("t2_inflight", 32'(last_word), 32'hF39F);
        frame(16, -1, '0, 0, '0, -1);
        check("t2_next", 32'(last_word), 32'h001F);

        for (int k = 0; k < 6; k++) begin
            r = $urandom;
            pulse_load(r[10:0]);
            model_temp = $signed(r[10:0]);
            frame(16, -1, '0, 0, '0, -1);
        end
        for (int k = 0; k < 3; k++) begin
            frame(int'($urandom_range(1, 15)), -1, '0, 0, '0, -1);
        end

        mode_ramp = 1'b1;
        pulse_load(11'd396);
        model_temp = 396;
        frame(16, -1, '0, 0, '0, -1);
        check("t3_396", 32'(last_word), 32'h319F);
        frame(16, -1, '0, 0, '0, -1);
        check("t3_400", 32'(last_word), 32'h321F);
        frame(16, -1, '0, 0, '0, -1);
        check("t3_wrap", 32'(last_word), 32'h001F);

        frame(7, -1, '0, 0, '0, -1);
        frame(16, -1, '0, 0, '0, -1);
        check("t4_no_ramp_on_abort", 32'(last_word), 32'h009F);
        for (int k = 0; k < 3; k++) begin
            frame(int'($urandom_range(1, 15)), -1, '0, 0, '0, -1);
            frame(16, -1, '0, 0, '0, -1);
        end

        mode_ramp = 1'b0;
        pulse_load(11'h055);
        model_temp = 'h55;
        frame(16, -1, '0, 1, 11'h0AA, -1);
        check("t5_old_at_fall", 32'(last_word), 32'h0ABF);
        frame(16, -1, '0, 0, '0, -1);
        check("t5_new_after", 32'(last_word), 32'h155F);
        mode_ramp = 1'b1;
        frame(16, -1, '0, 2, 11'h123, -1);
        mode_ramp = 1'b0;
        frame(16, -1, '0, 0, '0, -1);
        check("t5_load_beats_ramp", 32'(last_word), 32'h247F);

        pulse_load(11'h050);
        model_temp = 'h50;
        frame(16, -1, '0, 0, '0, 9);
        frame(16, -1, '0, 0, '0, -1);
        check("t6_reset_word", 32'(last_word), 32'h0C9F);
        check("t6_cnt", 32'(frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
